imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
Byte-stream program loader that fills the CPU instruction memory and then releases the core from reset. It accepts a framed, little-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words. Each word is written to the four IMEM byte banks (lane 0 = bits 7:0 … lane 3 = bits 31:24) through a word write port. It holds cpu_rst_n low until a complete, checksum-verified image has been written. It sits between a host link (UART/debug bridge) and the IMEM write side of cpu_sc_part.

Parameters:
ADDR_W, 8, IMEM word-address width.
MAX_WORDS, 256, largest accepted image length in words; must be ≤ 2**ADDR_W.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a new load and asserts CPU reset
in_data  in  8  stream byte
in_valid  in  1  byte valid
in_ready  out  1  loader can accept a byte
mem_we  out  1  IMEM word write strobe, one cycle
mem_addr  out  ADDR_W  IMEM word address
mem_wdata  out  32  IMEM write word: lane0 = [7:0] … lane3 = [31:24]
cpu_rst_n  out  1  active-low reset to the CPU core
done  out  1  image loaded and verified; CPU running
err  out  1  load failed (length or checksum)
words_loaded  out  ADDR_W+1  words written in the current load

Behaviour:
- Frame format: LEN_LO, LEN_HI (N, 16-bit little-endian), then N×4 data bytes (little-endian per word, word 0 first), then CSUM.
- CSUM is the XOR of both length bytes and all data bytes.
- A byte transfers only on a cycle with in_valid && in_ready. Gaps in in_valid are legal at any point.
- Reset values: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, done=0, err=0, words_loaded=0. After reset the CPU stays in reset until a successful load.
- States and transitions:
  - IDLE: in_ready=0. On start → LEN_LO; clear done, err, words_loaded and the checksum accumulator.
  - LEN_LO: in_ready=1. Latch low length byte → LEN_HI.
  - LEN_HI: in_ready=1. Latch high length byte. If N > MAX_WORDS → ERROR. If N == 0 → CSUM. Otherwise → DATA with byte index 0 and word address 0.
  - DATA: in_ready=1. Shift each byte into lane[byte index].
    - On the 4th byte: in the next cycle mem_we=1, mem_addr = word index, mem_wdata = assembled word, and words_loaded increments (registered, 1-cycle latency).
    - After word N-1 is accepted → CSUM.
  - CSUM: in_ready=1. Compare the received byte with the accumulator.
    - Match → RUN; cpu_rst_n=1 and done=1 from the following cycle.
    - Mismatch → ERROR.
  - RUN: in_ready=0; cpu_rst_n=1; done=1. On start → LEN_LO and cpu_rst_n=0 in the following cycle.
  - ERROR: in_ready=0; err=1; cpu_rst_n=0. On start → LEN_LO.
- start is ignored in LEN_LO, LEN_HI, DATA and CSUM.
- mem_we is never asserted outside DATA completion. Words already written before an error are not rolled back.
- Address wrap is impossible: N ≤ MAX_WORDS is enforced before the first write.
- rst_n asserted mid-load forces all reset values immediately. A partial load is abandoned and a fresh start is required.
- The 1-cycle write latency allows back-to-back bytes with no stall: at most one write is pending per 4 bytes.

Decomposition:
- Shared package:
  - state encoding enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, RUN, ERROR)
  - frame constants: LEN_BYTES=2, WORD_BYTES=4
- One sub-module, imem_word_assembler: byte-lane shift register, byte index counter and word-complete pulse.
- FSM, length check, checksum and address counting stay in the top module.

Test Plan:
- Load the 6-word program 00A00093, 01400113, 002081B3, 00302023, 00002203, 401202B3.
  - Stimulus: start, bytes 06 00, then 93 00 A0 00 13 01 40 01 …, CSUM 0x85.
  - Required: six mem_we pulses at addr 0..5 with exactly those words; words_loaded=6; done=1; cpu_rst_n=1; err=0.
- Same stream with CSUM 0x84 → err=1, done=0, cpu_rst_n stays 0; start then re-arms (in_ready=1 next cycle).
- Length 0x0101 (257, MAX_WORDS=256) → ERROR right after LEN_HI; no mem_we ever; in_ready=0.
- N=0, stream 00 00 00 → done=1, cpu_rst_n=1, zero writes.
- Randomly gapped in_valid during the 6-word load → identical writes and result as the first test; no byte lost or duplicated.
- rst_n pulsed low after word 2 of 6 → all outputs at reset values immediately; stream bytes ignored (in_ready=0) until the next start.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared state encoding and frame constants for the IMEM boot loader
package imem_boot_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, RUN, ERROR} state_t;
  localparam int LEN_BYTES = 2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs little-endian bytes into 32-bit words with a registered word-complete pulse
module imem_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_last,
  output logic        word_done
);
  localparam int IW = $clog2(WORD_BYTES);
  logic [IW-1:0] idx;
  assign word_last = byte_en && idx == IW'(WORD_BYTES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word      <= '0;
      idx       <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= word_last;
      if (clear) begin
        idx <= '0;
      end else if (byte_en) begin
        word[8*idx +: 8] <= in_data;
        idx              <= idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a framed, checksummed byte stream into IMEM and then releases the CPU from reset
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);
  localparam int HDR_BITS = 8 * LEN_BYTES;
  state_t                state, state_nx;
  logic                  xfer, rearm, word_last, last_word, n_big, n_zero;
  logic [7:0]            len_lo, csum;
  logic [ADDR_W:0]       len, word_cnt;
  logic [HDR_BITS-1:0]   n_full;
  assign in_ready     = state inside {LEN_LO, LEN_HI, DATA, CSUM};
  assign xfer         = in_valid && in_ready;
  assign rearm        = start && state inside {IDLE, RUN, ERROR};
  assign n_full       = {in_data, len_lo};
  assign n_big        = {1'b0, n_full} > (HDR_BITS + 1)'(MAX_WORDS);
  assign n_zero       = n_full == '0;
  assign last_word    = word_cnt + {{ADDR_W{1'b0}}, 1'b1} == len;
  assign cpu_rst_n    = state == RUN;
  assign done         = state == RUN;
  assign err          = state == ERROR;
  assign words_loaded = word_cnt;
  imem_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (rearm),
    .byte_en   (xfer && state == DATA),
    .in_data   (in_data),
    .word      (mem_wdata),
    .word_last (word_last),
    .word_done (mem_we)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, RUN, ERROR: state_nx = start ? LEN_LO : state;
      LEN_LO:           state_nx = xfer ? LEN_HI : state;
      LEN_HI:           state_nx = !xfer ? state : n_big ? ERROR : n_zero ? CSUM : DATA;
      DATA:             state_nx = (word_last && last_word) ? CSUM : state;
      CSUM:             state_nx = !xfer ? state : (in_data == csum) ? RUN : ERROR;
      default:          state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo   <= '0;
      len      <= '0;
      csum     <= '0;
      word_cnt <= '0;
      mem_addr <= '0;
    end else begin
      if (rearm) begin
        csum     <= '0;
        word_cnt <= '0;
        mem_addr <= '0;
      end else if (xfer && state inside {LEN_LO, LEN_HI, DATA}) begin
        csum <= csum ^ in_data;
      end
      if (xfer && state == LEN_LO) len_lo <= in_data;
      if (xfer && state == LEN_HI) len <= n_full[ADDR_W:0];
      if (word_last) begin
        mem_addr <= word_cnt[ADDR_W-1:0];
        word_cnt <= word_cnt + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed frames checked against an expected-write list and frame-level result model
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, cpu_rst_n, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  words_loaded;
  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int wr_base = 0;
  int exp_len = 0;
  logic [7:0]  exp_addr [64];
  logic [31:0] exp_data [64];
  logic [31:0] prog [6] = '{32'h00A00093, 32'h01400113, 32'h002081B3,
                            32'h00302023, 32'h00002203, 32'h401202B3};
  imem_boot_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .done(done), .err(err), .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] frame_csum(input int n);
    logic [7:0] x;
    x = n[7:0] ^ n[15:8];
    for (int i = 0; i < n; i++) x ^= prog[i][7:0] ^ prog[i][15:8] ^ prog[i][23:16] ^ prog[i][31:24];
    return x;
  endfunction
  task automatic expect_writes(input int n);
    for (int i = 0; i < n; i++) begin
      exp_addr[exp_len] = 8'(i);
      exp_data[exp_len] = prog[i];
      exp_len++;
    end
  endtask
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wr_base = wr_cnt;
  endtask
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    in_data = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL handshake_timeout actual=in_ready_low expected=in_ready_high");
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask
  task automatic send_frame(input int n, input int nw, input logic [7:0] cs, input bit gap);
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int i = 0; i < nw; i++)
      for (int b = 0; b < 4; b++) send_byte(prog[i][8*b +: 8], gap);
    send_byte(cs, gap);
  endtask
  task automatic check_ok(input string tag, input int n);
    repeat (2) begin @(posedge clk); #1; end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(n));
    chk({tag, "_all_writes"}, 32'(wr_cnt), 32'(exp_len));
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (mem_we) begin
            if (wr_cnt >= exp_len) begin
              chk("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
              chk("write_addr", 32'(mem_addr), 32'(exp_addr[wr_cnt]));
              chk("write_data", mem_wdata, exp_data[wr_cnt]);
            end
            wr_cnt++;
          end
          chk("words_loaded_track", 32'(words_loaded), 32'(wr_cnt - wr_base));
          chk("cpu_rst_vs_done", 32'(cpu_rst_n), 32'(done));
        end
      end
    join_none
    chk("model_csum_good", 32'(frame_csum(6)), 32'h85);
    chk("model_csum_empty", 32'(frame_csum(0)), 32'h00);
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_words_loaded", 32'(words_loaded), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_cpu_held", 32'(cpu_rst_n), 32'd0);
    // good 6-word image
    do_start();
    expect_writes(6);
    send_frame(6, 6, 8'h85, 1'b0);
    check_ok("load6", 6);
    // bad checksum: words still land, CPU stays in reset
    do_start();
    chk("rerun_cpu_reset", 32'(cpu_rst_n), 32'd0);
    expect_writes(6);
    send_frame(6, 6, 8'h84, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    chk("badcs_err", 32'(err), 32'd1);
    chk("badcs_done", 32'(done), 32'd0);
    chk("badcs_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("badcs_in_ready", 32'(in_ready), 32'd0);
    chk("badcs_writes", 32'(wr_cnt), 32'(exp_len));
    do_start();
    chk("rearm_in_ready", 32'(in_ready), 32'd1);
    chk("rearm_err_clear", 32'(err), 32'd0);
    // oversize length 257
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    chk("big_err", 32'(err), 32'd1);
    chk("big_in_ready", 32'(in_ready), 32'd0);
    chk("big_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("big_no_writes", 32'(wr_cnt), 32'(exp_len));
    // empty image
    do_start();
    send_frame(0, 0, 8'h00, 1'b0);
    check_ok("empty", 0);
    // gapped 6-word image
    do_start();
    expect_writes(6);
    send_frame(6, 6, 8'h85, 1'b1);
    check_ok("gapped", 6);
    // reset after word 2
    do_start();
    expect_writes(6);
    send_byte(8'h06, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++) send_byte(prog[i][8*b +: 8], 1'b0);
    @(posedge clk); #1;
    chk("mid_words_before_rst", 32'(wr_cnt - wr_base), 32'd2);
    rst_n = 1'b0;
    #1;
    exp_len = wr_cnt;
    wr_base = wr_cnt;
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    chk("mid_mem_we", 32'(mem_we), 32'd0);
    chk("mid_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_mem_wdata", mem_wdata, 32'd0);
    chk("mid_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_err", 32'(err), 32'd0);
    chk("mid_words_loaded", 32'(words_loaded), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = prog[2][7:0];
    repeat (5) begin
      @(posedge clk); #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("post_rst_words", 32'(words_loaded), 32'd0);
    chk("post_rst_no_writes", 32'(wr_cnt), 32'(exp_len));
    chk("post_rst_cpu_held", 32'(cpu_rst_n), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
